alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshakes on input and output, full backpressure, status flags, rotate ops, and a passthrough transaction tag. Successor to the single-cycle ALU: same op set plus rotates and signed compare, any data width, one-op-per-cycle throughput under stall. Sits between the issue logic (input side) and the writeback/scoreboard (output side). Tags return in order.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥8.
- TAG_W, 4: width of the opaque tag carried with each op.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  op presented.
- in_ready  out  1  block accepts op this cycle.
- in_op  in  4  alu_op_e opcode.
- in_a, in_b  in  WIDTH  operands.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_flags  out  4  {N, Z, C, V}.
- out_err  out  1  illegal opcode.
- out_tag  out  TAG_W  tag of this result.

## Operation
- One clock, one reset as stated above: clk, reset_n async active-low.
- Ops (alu_op_e): ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, ROL 8, ROR 9, EQ 10, GTU 11, LTS 12; 13–15 illegal.
- Shift/rotate amount = in_b[$clog2(WIDTH)-1:0]; upper bits of in_b ignored (shift by WIDTH is shift by 0).
- EQ/GTU/LTS: result = {WIDTH-1 zeros, bit}; GTU unsigned A>B, LTS signed A<B.
- Flags: Z = (result==0); N = result[WIDTH-1]; C = carry-out for ADD, borrow (A<B unsigned) for SUB, last bit shifted out for SLL/SRL/SRA (0 if amount 0), 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
- Illegal op: out_result 0, out_flags 0, out_err 1; tag still returned; pipeline not stalled.
- Stage 1 (S1): registers op, a, b, tag on in_valid && in_ready.
- Stage 2 (S2): computes from S1, registers result/flags/err/tag; drives out_*.
- Per-stage valid bit. S2 loads when S1 valid and (!S2 valid || out_ready). S1 loads/advances when (!S1 valid || S2 can load).
- in_ready = !s1_valid || !s2_valid || out_ready (combinational, no path from in_valid).
- Stall: out_valid && !out_ready holds out_* stable; S1 fills then in_ready drops. No op is dropped or duplicated.

## Timing
- Reset (async assert, sync release into clk): s1_valid, out_valid, out_result, out_flags, out_err, out_tag all 0; in_ready 1 while reset_n is low and after release.
- Latency: op accepted at edge k → out_valid at edge k+2 (visible cycle after k+1), if no stall.
- Throughput: 1 op/cycle with out_ready held high.
- Simultaneous accept at output and input in same cycle: both handshakes complete; pipeline shifts.
- out_* may change only after a completed output handshake or when out_valid is 0.
- Reset mid-operation: in-flight ops discarded, no out_valid after release until new input.
- Max 2 ops in flight; in_ready low only when both stages full and out_ready low.

## Structure
- alu_pkg: alu_op_e (4-bit enum above), flag bit index constants (FLAG_N 3, FLAG_Z 2, FLAG_C 1, FLAG_V 0).
- Sub-module alu_core: purely combinational, parametrised by WIDTH: op, a, b → result, flags, err. Includes barrel shifter/rotator. alu_pipe holds stage regs and handshake.
- Top ~250 lines total.

## Test plan
- Reset: reset_n low mid-stream with 2 ops in flight → out_valid 0, in_ready 1, no stale result after release.
- WIDTH=8 ADD 0xFF+0x01 → result 0x00, flags Z=1 C=1 V=0 N=0; ADD 0x7F+0x01 → 0x80, N=1 V=1 C=0.
- WIDTH=8 SUB 0x00−0x01 → 0xFF, N=1 C=1; SRA 0x80 by 3 → 0xF0; ROL 0x81 by 1 → 0x03; SLL 0x01 by in_b=8 → 0x01 (amount 0), C=0.
- Back-to-back 16 ops, out_ready high → results on 16 consecutive cycles, tags 0..15 in order, first at 2 cycles after first accept.
- Backpressure: out_ready low 5 cycles during stream → out_* stable, in_ready low after 2 ops buffered, all tags delivered once, in order.
- Opcode 14 with tag 0x9 → out_err 1, result 0, flags 0, out_tag 0x9; next op LTS 0x80 vs 0x01 (WIDTH=8) → result 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_XOR = 4'd2,
      OP_OR  = 4'd3,
      OP_AND = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_SRA = 4'd7,
      OP_ROL = 4'd8,
      OP_ROR = 4'd9,
      OP_EQ  = 4'd10,
      OP_GTU = 4'd11,
      OP_LTS = 4'd12
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: arithmetic, logic, barrel shift/rotate and compares.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);

   localparam int SW = $clog2(WIDTH);

   logic [SW-1:0]    shamt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   sll_ext;
   logic [WIDTH:0]   srl_ext;
   logic [WIDTH:0]   sra_ext;
   logic [WIDTH-1:0] rol_res;
   logic [WIDTH-1:0] ror_res;
   logic             carry;
   logic             ovf;

   assign shamt = b[SW-1:0];
   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = {1'b0, a} - {1'b0, b};

   // One guard bit beside the operand catches the last bit shifted out (zero when amount is 0).
   assign sll_ext = {1'b0, a} << shamt;
   assign srl_ext = {a, 1'b0} >> shamt;
   assign sra_ext = $signed({a, 1'b0}) >>> shamt;
   assign rol_res = (a << shamt) | (a >> (WIDTH - int'(shamt)));
   assign ror_res = (a >> shamt) | (a << (WIDTH - int'(shamt)));

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      err    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
            ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR: result = a ^ b;
         OP_OR:  result = a | b;
         OP_AND: result = a & b;
         OP_SLL: begin
            result = sll_ext[WIDTH-1:0];
            carry  = sll_ext[WIDTH];
         end
         OP_SRL: begin
            result = srl_ext[WIDTH:1];
            carry  = srl_ext[0];
         end
         OP_SRA: begin
            result = sra_ext[WIDTH:1];
            carry  = sra_ext[0];
         end
         OP_ROL: result = rol_res;
         OP_ROR: result = ror_res;
         OP_EQ:  result = {{(WIDTH-1){1'b0}}, a == b};
         OP_GTU: result = {{(WIDTH-1){1'b0}}, a > b};
         OP_LTS: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         default: err = 1'b1;
      endcase
   end

   always_comb begin
      flags = '0;
      if (!err) begin
         flags[FLAG_N] = result[WIDTH-1];
         flags[FLAG_Z] = (result == '0);
         flags[FLAG_C] = carry;
         flags[FLAG_V] = ovf;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides; operands are captured in S1,
// the result is computed from S1 and registered into the output stage S2.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   logic             s1_valid;
   alu_op_e          s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_load;
   logic             s2_load;
   logic [WIDTH-1:0] core_result;
   logic [3:0]       core_flags;
   logic             core_err;

   // Input side only blocks when both stages hold ops and the consumer is stalling.
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign s1_load  = in_valid && in_ready;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
      .result (core_result),
      .flags  (core_flags),
      .err    (core_err)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tag   <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_op    <= alu_op_e'(in_op);
         s1_a     <= in_a;
         s1_b     <= in_b;
         s1_tag   <= in_tag;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Output registers only change on a load, so a stalled result stays put.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         out_err    <= 1'b0;
         out_tag    <= '0;
      end else if (s2_load) begin
         out_valid  <= 1'b1;
         out_result <= core_result;
         out_flags  <= core_flags;
         out_err    <= core_err;
         out_tag    <= s1_tag;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: expected results are queued on input
// handshakes and compared on output handshakes.
module tb_alu_pipe;

   typedef struct packed {
      logic [7:0] result;
      logic [3:0] flags;
      logic       err;
      logic [3:0] tag;
   } res_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] in_tag;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic [3:0] out_flags;
   logic       out_err;
   logic [3:0] out_tag;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_err    (out_err),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   // Reference model written as bit-serial shifts and integer arithmetic.
   function automatic res_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [3:0] tag);
      res_t       r;
      logic [7:0] v;
      logic       c;
      logic       o;
      int         s;
      int         sh;
      sh = int'(b[2:0]);
      v = '0; c = 1'b0; o = 1'b0;
      r.err = 1'b0;
      case (op)
         4'd0: begin
            s = int'(a) + int'(b); v = s[7:0]; c = (s > 255);
            s = int'($signed(a)) + int'($signed(b)); o = (s > 127) || (s < -128);
         end
         4'd1: begin
            s = int'(a) - int'(b); v = s[7:0]; c = (a < b);
            s = int'($signed(a)) - int'($signed(b)); o = (s > 127) || (s < -128);
         end
         4'd2: v = a ^ b;
         4'd3: v = a | b;
         4'd4: v = a & b;
         4'd5: begin v = a; for (int i = 0; i < sh; i++) begin c = v[7]; v = {v[6:0], 1'b0}; end end
         4'd6: begin v = a; for (int i = 0; i < sh; i++) begin c = v[0]; v = {1'b0, v[7:1]}; end end
         4'd7: begin v = a; for (int i = 0; i < sh; i++) begin c = v[0]; v = {v[7], v[7:1]}; end end
         4'd8: begin v = a; for (int i = 0; i < sh; i++) v = {v[6:0], v[7]}; end
         4'd9: begin v = a; for (int i = 0; i < sh; i++) v = {v[0], v[7:1]}; end
         4'd10: v = (a == b) ? 8'd1 : 8'd0;
         4'd11: v = (a > b) ? 8'd1 : 8'd0;
         4'd12: v = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
         default: r.err = 1'b1;
      endcase
      r.result = r.err ? 8'h00 : v;
      r.flags  = r.err ? 4'h0 : {v[7], v == 8'h00, c, o};
      r.tag    = tag;
      return r;
   endfunction

   task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] tag, input bit ordy,
                                output bit acc, output bit deliv, output res_t got);
      @(negedge clk);
      in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
      #1;
      acc   = in_valid && in_ready;
      deliv = out_valid && out_ready;
      got   = {out_result, out_flags, out_err, out_tag};
      if (acc) exp_q.push_back(model(op, a, b, tag));
   endtask

   task automatic pop_exp(output res_t e, output bit ok);
      ok = (exp_q.size() > 0);
      e  = ok ? exp_q.pop_front() : '0;
   endtask

   task automatic test_reset();
      bit acc, deliv, ok;
      res_t got;
      reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({out_valid, out_result, out_flags, out_err, out_tag, in_ready} !== {1'b0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset_state: got v=%b r=%h f=%h e=%b t=%h rdy=%b required all 0 with rdy=1",
                  out_valid, out_result, out_flags, out_err, out_tag, in_ready);
      end
      @(negedge clk) reset_n = 1'b1;
      applyStimulus(1, 4'd0, 8'h11, 8'h22, 4'h1, 0, acc, deliv, got);
      applyStimulus(1, 4'd2, 8'h33, 8'h44, 4'h2, 0, acc, deliv, got);
      applyStimulus(0, 4'd0, 8'h00, 8'h00, 4'h0, 0, acc, deliv, got);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_full: got in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_midstream: got out_valid=%b in_ready=%b result=%h required 0/1/00",
                  out_valid, in_ready, out_result);
      end
      @(negedge clk) reset_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 4'd0, 8'h00, 8'h00, 4'h0, 1, acc, deliv, got);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_stale: cycle %0d got out_valid=%b required 0", i, out_valid);
         end
      end
      pop_exp(got, ok);
   endtask

   task automatic test_directed();
      logic [3:0] ops  [8] = '{4'd0, 4'd0, 4'd1, 4'd7, 4'd8, 4'd5, 4'd14, 4'd12};
      logic [7:0] as   [8] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h81, 8'h01, 8'h5A, 8'h80};
      logic [7:0] bs   [8] = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h01, 8'h08, 8'h3C, 8'h01};
      logic [3:0] tags [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'h7};
      res_t       want [8] = '{{8'h00, 4'b0110, 1'b0, 4'h0}, {8'h80, 4'b1001, 1'b0, 4'h1},
                               {8'hFF, 4'b1010, 1'b0, 4'h2}, {8'hF0, 4'b1000, 1'b0, 4'h3},
                               {8'h03, 4'b0000, 1'b0, 4'h4}, {8'h01, 4'b0000, 1'b0, 4'h5},
                               {8'h00, 4'b0000, 1'b1, 4'h9}, {8'h01, 4'b0000, 1'b0, 4'h7}};
      bit acc, deliv, ok, seen;
      res_t got, e;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, ops[i], as[i], bs[i], tags[i], 1, acc, deliv, got);
         seen = 1'b0;
         for (int w = 0; w < 6 && !seen; w++) begin
            applyStimulus(0, 4'd0, 8'h00, 8'h00, 4'h0, 1, acc, deliv, got);
            if (deliv) begin
               seen = 1'b1;
               pop_exp(e, ok);
               checks++;
               if (!ok || got !== e || got !== want[i]) begin
                  errors++;
                  $display("[TB] FAIL directed_%0d: got %h model %h required %h", i, got, e, want[i]);
               end
            end
         end
         if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL directed_timeout_%0d: got no result required one", i);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit acc, deliv, ok;
      res_t got, e;
      int first_acc = -1;
      int ndel = 0;
      for (int s = 0; s < 22; s++) begin
         applyStimulus(s < 16, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 4'(s), 1, acc, deliv, got);
         if (acc && first_acc < 0) first_acc = s;
         if (deliv) begin
            pop_exp(e, ok);
            checks++;
            if (!ok || got !== e || got.tag !== 4'(ndel) || s !== first_acc + 2 + ndel) begin
               errors++;
               $display("[TB] FAIL b2b_%0d: got %h at step %0d required %h tag %0d at step %0d",
                        ndel, got, s, e, ndel, first_acc + 2 + ndel);
            end
            ndel++;
         end
      end
      checks++;
      if (ndel != 16) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d results required 16", ndel);
      end
   endtask

   task automatic test_backpressure();
      bit acc, deliv, ok, ordy, prev_stall, saw_full;
      res_t got, e, snap;
      int issued = 0, ndel = 0, inflight = 0;
      prev_stall = 1'b0; saw_full = 1'b0; snap = '0;
      for (int s = 0; s < 60 && ndel < 12; s++) begin
         ordy = !(s >= 3 && s < 8);
         applyStimulus(issued < 12, 4'($urandom_range(0, 12)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 4'(issued), ordy, acc, deliv, got);
         checks++;
         if (in_ready !== ((inflight < 2) || ordy)) begin
            errors++;
            $display("[TB] FAIL bp_in_ready: step %0d got %b required %b", s, in_ready, (inflight < 2) || ordy);
         end
         if (!in_ready) saw_full = 1'b1;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || got !== snap) begin
               errors++;
               $display("[TB] FAIL bp_stable: step %0d got v=%b %h required v=1 %h", s, out_valid, got, snap);
            end
         end
         if (deliv) begin
            pop_exp(e, ok);
            checks++;
            if (!ok || got !== e || got.tag !== 4'(ndel)) begin
               errors++;
               $display("[TB] FAIL bp_result_%0d: got %h required %h", ndel, got, e);
            end
            ndel++;
         end
         if (acc) issued++;
         inflight   = inflight + int'(acc) - int'(deliv);
         prev_stall = out_valid && !ordy;
         snap       = got;
      end
      checks++;
      if (ndel != 12 || !saw_full) begin
         errors++;
         $display("[TB] FAIL bp_summary: got %0d results full=%b required 12 full=1", ndel, saw_full);
      end
   endtask

   task automatic test_random();
      bit acc, deliv, ok, ordy;
      res_t got, e;
      logic [3:0] tag = '0;
      int inflight = 0;
      for (int s = 0; s < 100; s++) begin
         ordy = (s >= 80) || ($urandom_range(0, 3) != 0);
         applyStimulus((s < 80) && ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), tag, ordy, acc, deliv, got);
         checks++;
         if (in_ready !== ((inflight < 2) || ordy)) begin
            errors++;
            $display("[TB] FAIL rnd_in_ready: step %0d got %b required %b", s, in_ready, (inflight < 2) || ordy);
         end
         if (deliv) begin
            pop_exp(e, ok);
            checks++;
            if (!ok || got !== e) begin
               errors++;
               $display("[TB] FAIL rnd_result: step %0d got %h required %h", s, got, e);
            end
         end
         if (acc) tag++;
         inflight = inflight + int'(acc) - int'(deliv);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL rnd_drain: got %0d pending results required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
